// File: rtl/l1i_pkg.sv
// Shared types and helpers for the N-way L1 instruction-cache controller.
//   state_t      : controller FSM state encoding
//   DEF_*        : default parameter values for the controller and its interface
//   plru_victim  : tree-PLRU victim way for one set
//   plru_update  : tree-PLRU bits after an access to a given way
// PLRU tree layout: heap order, node 0 is the root, children of node n are 2n+1 (left) and
// 2n+2 (right). A node bit of 0 means the victim lies to the left.
package l1i_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StCompare  = 2'b01,
    StAllocate = 2'b11,
    StRefill   = 2'b10
  } state_t;

  localparam int unsigned DEF_TAG_W    = 24;
  localparam int unsigned DEF_IDX_W    = 2;
  localparam int unsigned DEF_WAYS     = 2;
  localparam int unsigned DEF_L2_IDX_W = 5;
  localparam int unsigned DEF_CNT_W    = 16;

  // Helpers are sized for the largest supported associativity (8 ways).
  localparam int unsigned WAY_MAX_W  = 3;
  localparam int unsigned PLRU_MAX_W = 7;

  // Walk from the root following each node bit; the path taken is the victim way number.
  function automatic logic [WAY_MAX_W-1:0] plru_victim(input logic [PLRU_MAX_W-1:0] bits,
                                                       input int levels);
    logic [2:0] node;
    logic [2:0] way;
    node = '0;
    way  = '0;
    for (int l = 0; l < int'(WAY_MAX_W); l++) begin
      if (l < levels) begin
        way  = {way[1:0], bits[node]};
        node = {node[1:0], 1'b0} + 3'd1 + {2'b00, bits[node]};
      end
    end
    return way;
  endfunction

  // Every node on the path to the accessed way is set to point away from it.
  function automatic logic [PLRU_MAX_W-1:0] plru_update(input logic [PLRU_MAX_W-1:0] bits,
                                                        input logic [WAY_MAX_W-1:0] way,
                                                        input int levels);
    logic [PLRU_MAX_W-1:0] upd;
    logic [2:0]            node;
    logic [2:0]            path;
    logic                  dir;
    upd  = bits;
    node = '0;
    for (int l = 0; l < int'(WAY_MAX_W); l++) begin
      if (l < levels) begin
        path      = way >> (levels - 1 - l);
        dir       = path[0];
        upd[node] = ~dir;
        node      = {node[1:0], 1'b0} + 3'd1 + {2'b00, dir};
      end
    end
    return upd;
  endfunction

endpackage

// File: rtl/l1i_ctrl_nway_if.sv
// Fetch-port / L2-port bundle of the N-way L1I controller.
//   slave  : controller side (takes fetch + L2 ready, drives stall/hit/miss/refill/L2 request)
//   master : requester side (CPU fetch unit, L2 model, counter consumer)
interface l1i_ctrl_nway_if #(
  parameter int unsigned TAG_W    = 24,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned L2_IDX_W = 5,
  parameter int unsigned CNT_W    = 16
);
  localparam int unsigned WAY_W    = $clog2(WAYS);
  localparam int unsigned L2_TAG_W = TAG_W + IDX_W - L2_IDX_W;

  logic [TAG_W-1:0]    tag_i;
  logic [IDX_W-1:0]    index_i;
  logic                read_i;
  logic                flush_i;
  logic                ready_l2_i;
  logic                cnt_clr_i;
  logic                stall_o;
  logic                hit_o;
  logic                miss_o;
  logic                refill_o;
  logic                read_l2_o;
  logic [L2_TAG_W-1:0] tag_l2_o;
  logic [L2_IDX_W-1:0] index_l2_o;
  logic [WAY_W-1:0]    way_o;
  logic [CNT_W-1:0]    hit_cnt_o;
  logic [CNT_W-1:0]    miss_cnt_o;

  modport slave (
    input  tag_i, index_i, read_i, flush_i, ready_l2_i, cnt_clr_i,
    output stall_o, hit_o, miss_o, refill_o, read_l2_o, tag_l2_o, index_l2_o, way_o,
           hit_cnt_o, miss_cnt_o
  );

  modport master (
    output tag_i, index_i, read_i, flush_i, ready_l2_i, cnt_clr_i,
    input  stall_o, hit_o, miss_o, refill_o, read_l2_o, tag_l2_o, index_l2_o, way_o,
           hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/l1i_plru.sv
// Combinational tree-PLRU for one set.
//   bits       : current PLRU bits of the set (WAYS-1)
//   access_way : way being accessed (hit or fill)
//   victim     : way the tree currently points at
//   next_bits  : set bits after an access to access_way
module l1i_plru
  import l1i_pkg::*;
#(
  parameter int unsigned WAYS = DEF_WAYS
) (
  input  logic [WAYS-2:0]         bits,
  input  logic [$clog2(WAYS)-1:0] access_way,
  output logic [$clog2(WAYS)-1:0] victim,
  output logic [WAYS-2:0]         next_bits
);
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned PLRU_W = WAYS - 1;
  localparam int          LEVELS = $clog2(WAYS);

  logic [PLRU_MAX_W-1:0] bits_ext;
  logic [PLRU_MAX_W-1:0] next_ext;
  logic [WAY_MAX_W-1:0]  way_ext;
  logic [WAY_MAX_W-1:0]  victim_ext;

  always_comb begin
    bits_ext               = '0;
    bits_ext[PLRU_W-1:0]   = bits;
    way_ext                = '0;
    way_ext[WAY_W-1:0]     = access_way;
    victim_ext             = plru_victim(bits_ext, LEVELS);
    next_ext               = plru_update(bits_ext, way_ext, LEVELS);
  end

  assign victim    = victim_ext[WAY_W-1:0];
  assign next_bits = next_ext[PLRU_W-1:0];

  // Upper bits of the fixed-width helpers are don't-care for narrower trees.
  logic unused_ext;
  assign unused_ext = ^{victim_ext, next_ext};

endmodule

// File: rtl/l1i_ctrl_nway.sv
// N-way set-associative L1 instruction-cache controller.
//   clk, nrst : clock, asynchronous active-low reset
//   bus       : slave side of l1i_ctrl_nway_if
//               in : tag_i, index_i, read_i, flush_i, ready_l2_i, cnt_clr_i
//               out: stall_o, hit_o, miss_o, refill_o, read_l2_o, tag_l2_o, index_l2_o,
//                    way_o, hit_cnt_o, miss_cnt_o
// Holds the tag/valid/PLRU arrays; the data array lives outside and follows
// way_o / refill_o.
module l1i_ctrl_nway
  import l1i_pkg::*;
#(
  parameter int unsigned TAG_W    = DEF_TAG_W,
  parameter int unsigned IDX_W    = DEF_IDX_W,
  parameter int unsigned WAYS     = DEF_WAYS,
  parameter int unsigned L2_IDX_W = DEF_L2_IDX_W,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic           clk,
  input  logic           nrst,
  l1i_ctrl_nway_if.slave bus
);
  localparam int unsigned WAY_W  = $clog2(WAYS);
  localparam int unsigned SETS   = 2 ** IDX_W;
  localparam int unsigned PLRU_W = WAYS - 1;
  localparam int unsigned ADDR_W = TAG_W + IDX_W;

  state_t state_q, state_d;

  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [PLRU_W-1:0] plru_q  [SETS];

  logic [TAG_W-1:0] req_tag_q;
  logic [IDX_W-1:0] req_idx_q;
  logic             first_pass_q, first_pass_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic             hit_q, hit_d;
  logic             miss_q, miss_d;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  logic accept, flush, fill_we, plru_we;

  // Lookup on the latched request.
  logic [WAYS-1:0]   valid_set;
  logic [WAYS-1:0]   match;
  logic [WAY_W-1:0]  hit_way, inv_way, plru_way, victim, access_way;
  logic              hit_any, has_invalid;
  logic [PLRU_W-1:0] plru_next;

  always_comb begin
    valid_set = valid_q[req_idx_q];
    match     = '0;
    hit_way   = '0;
    inv_way   = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      match[w] = valid_set[w] && (tag_q[req_idx_q][w] == req_tag_q);
    end
    for (int w = 0; w < int'(WAYS); w++) begin
      if (match[w]) hit_way = WAY_W'(w);
    end
    // Descending scan leaves the lowest-numbered invalid way.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (!valid_set[w]) inv_way = WAY_W'(w);
    end
  end

  assign hit_any     = |match;
  assign has_invalid = ~&valid_set;
  assign victim      = has_invalid ? inv_way : plru_way;
  // Hits update toward the matching way; fills toward the allocated way.
  assign access_way  = (state_q == StCompare) ? hit_way : way_q;

  l1i_plru #(
    .WAYS (WAYS)
  ) u_plru (
    .bits       (plru_q[req_idx_q]),
    .access_way (access_way),
    .victim     (plru_way),
    .next_bits  (plru_next)
  );

  always_comb begin
    state_d      = state_q;
    first_pass_d = first_pass_q;
    way_d        = way_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    accept       = 1'b0;
    flush        = 1'b0;
    fill_we      = 1'b0;
    plru_we      = 1'b0;
    unique case (state_q)
      StIdle: begin
        flush = bus.flush_i;
        if (bus.read_i) begin
          accept       = 1'b1;
          first_pass_d = 1'b1;
          state_d      = StCompare;
        end
      end
      StCompare: begin
        if (hit_any) begin
          hit_d   = 1'b1;
          way_d   = hit_way;
          plru_we = 1'b1;
          state_d = StIdle;
        end else begin
          way_d   = victim;
          // The compare after a refill must not report a second miss.
          miss_d  = first_pass_q;
          state_d = StAllocate;
        end
      end
      StAllocate: begin
        if (bus.ready_l2_i) begin
          fill_we      = 1'b1;
          plru_we      = 1'b1;
          first_pass_d = 1'b0;
          state_d      = StRefill;
        end
      end
      StRefill: begin
        state_d = StCompare;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= StIdle;
      req_tag_q    <= '0;
      req_idx_q    <= '0;
      first_pass_q <= 1'b0;
      way_q        <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      first_pass_q <= first_pass_d;
      way_q        <= way_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      if (accept) begin
        req_tag_q <= bus.tag_i;
        req_idx_q <= bus.index_i;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int s = 0; s < int'(SETS); s++) begin
        valid_q[s] <= '0;
        plru_q[s]  <= '0;
        for (int w = 0; w < int'(WAYS); w++) begin
          tag_q[s][w] <= '0;
        end
      end
    end else begin
      if (flush) begin
        for (int s = 0; s < int'(SETS); s++) begin
          valid_q[s] <= '0;
        end
      end
      if (fill_we) begin
        valid_q[req_idx_q][way_q] <= 1'b1;
        tag_q[req_idx_q][way_q]   <= req_tag_q;
      end
      if (plru_we) begin
        plru_q[req_idx_q] <= plru_next;
      end
    end
  end

  // Counters follow the registered pulses; clear wins over increment.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (bus.cnt_clr_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_q && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (miss_q && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  logic [ADDR_W-1:0] req_addr;
  assign req_addr = {req_tag_q, req_idx_q};

  assign bus.stall_o    = (state_q != StIdle);
  assign bus.hit_o      = hit_q;
  assign bus.miss_o     = miss_q;
  assign bus.refill_o   = (state_q == StRefill);
  assign bus.read_l2_o  = (state_q == StAllocate);
  assign bus.tag_l2_o   = req_addr[ADDR_W-1:L2_IDX_W];
  assign bus.index_l2_o = req_addr[L2_IDX_W-1:0];
  assign bus.way_o      = way_q;
  assign bus.hit_cnt_o  = hit_cnt_q;
  assign bus.miss_cnt_o = miss_cnt_q;

endmodule

// File: tb/tb_l1i_ctrl_nway.sv
// Directed bench for l1i_ctrl_nway: a 2-way instance with 4-bit counters and a 4-way
// instance with 16-bit counters, selected by 'sel' onto shared stimulus/observation wires.
module tb_l1i_ctrl_nway;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst2, nrst4;
  bit          sel;
  logic [23:0] tag;
  logic [1:0]  idx;
  logic        read, flush, ready, cnt_clr;

  int n_pass  = 0;
  int n_total = 0;

  l1i_ctrl_nway_if #(.TAG_W(24), .IDX_W(2), .WAYS(2), .L2_IDX_W(5), .CNT_W(4)) if2 ();
  l1i_ctrl_nway_if #(.TAG_W(24), .IDX_W(2), .WAYS(4), .L2_IDX_W(5), .CNT_W(16)) if4 ();

  l1i_ctrl_nway #(.TAG_W(24), .IDX_W(2), .WAYS(2), .L2_IDX_W(5), .CNT_W(4)) u_dut2 (
    .clk  (clk),
    .nrst (nrst2),
    .bus  (if2.slave)
  );

  l1i_ctrl_nway #(.TAG_W(24), .IDX_W(2), .WAYS(4), .L2_IDX_W(5), .CNT_W(16)) u_dut4 (
    .clk  (clk),
    .nrst (nrst4),
    .bus  (if4.slave)
  );

  assign if2.tag_i      = tag;
  assign if2.index_i    = idx;
  assign if2.read_i     = read & ~sel;
  assign if2.flush_i    = flush & ~sel;
  assign if2.ready_l2_i = ready & ~sel;
  assign if2.cnt_clr_i  = cnt_clr & ~sel;
  assign if4.tag_i      = tag;
  assign if4.index_i    = idx;
  assign if4.read_i     = read & sel;
  assign if4.flush_i    = flush & sel;
  assign if4.ready_l2_i = ready & sel;
  assign if4.cnt_clr_i  = cnt_clr & sel;

  logic        stall, hit, miss, refill, rl2;
  logic [1:0]  way;
  logic [20:0] tag_l2;
  logic [4:0]  index_l2;
  logic [15:0] hit_cnt, miss_cnt;

  assign stall    = sel ? if4.stall_o    : if2.stall_o;
  assign hit      = sel ? if4.hit_o      : if2.hit_o;
  assign miss     = sel ? if4.miss_o     : if2.miss_o;
  assign refill   = sel ? if4.refill_o   : if2.refill_o;
  assign rl2      = sel ? if4.read_l2_o  : if2.read_l2_o;
  assign way      = sel ? if4.way_o      : {1'b0, if2.way_o};
  assign tag_l2   = sel ? if4.tag_l2_o   : if2.tag_l2_o;
  assign index_l2 = sel ? if4.index_l2_o : if2.index_l2_o;
  assign hit_cnt  = sel ? if4.hit_cnt_o  : {12'b0, if2.hit_cnt_o};
  assign miss_cnt = sel ? if4.miss_cnt_o : {12'b0, if2.miss_cnt_o};

  // Cycle monitor, sampled 1 time unit after each rising edge.
  int          m_stall = 0, m_rl2 = 0, m_refill = 0, m_hit = 0, m_miss = 0;
  logic [1:0]  m_refill_way = '0, m_hit_way = '0;
  logic [20:0] m_l2_tag = '0;
  logic [4:0]  m_l2_idx = '0;

  always @(posedge clk) begin
    #1;
    if (stall) m_stall++;
    if (rl2) begin
      m_rl2++;
      m_l2_tag = tag_l2;
      m_l2_idx = index_l2;
    end
    if (refill) begin
      m_refill++;
      m_refill_way = way;
    end
    if (hit) begin
      m_hit++;
      m_hit_way = way;
    end
    if (miss) m_miss++;
  end

  int d_stall, d_rl2, d_refill, d_hit, d_miss;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  // One fetch; L2 answers in the (dly+1)-th ALLOCATE cycle. Returns at the first
  // falling edge with stall_o low, where a hit pulse is visible.
  task automatic fetch(input logic [23:0] t, input logic [1:0] ix, input int dly,
                       input bit with_flush);
    int b_stall, b_rl2, b_refill, b_hit, b_miss, alloc_n;
    bit done;
    @(negedge clk);
    b_stall = m_stall; b_rl2 = m_rl2; b_refill = m_refill; b_hit = m_hit; b_miss = m_miss;
    tag = t; idx = ix; read = 1'b1; flush = with_flush;
    @(negedge clk);
    read = 1'b0; flush = 1'b0;
    alloc_n = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (!stall) begin
        done = 1'b1;
      end else begin
        if (rl2) begin
          ready = (alloc_n == dly);
          alloc_n++;
        end else begin
          ready = 1'b0;
        end
        @(negedge clk);
      end
    end
    ready = 1'b0;
    chk("fetch_completes", {31'b0, done}, 32'd1);
    d_stall  = m_stall - b_stall;
    d_rl2    = m_rl2 - b_rl2;
    d_refill = m_refill - b_refill;
    d_hit    = m_hit - b_hit;
    d_miss   = m_miss - b_miss;
  endtask

  logic [23:0] tl [5];

  initial begin
    tl[0] = 24'h00000A; tl[1] = 24'h00000B; tl[2] = 24'h00000C;
    tl[3] = 24'h00000D; tl[4] = 24'h00000E;
    nrst2 = 1'b0; nrst4 = 1'b0; sel = 1'b0;
    tag = '0; idx = '0; read = 1'b0; flush = 1'b0; ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    nrst2 = 1'b1; nrst4 = 1'b1;
    @(negedge clk);

    // Reset state, 2-way instance
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_hit", {31'b0, hit}, 32'd0);
    chk("rst_miss", {31'b0, miss}, 32'd0);
    chk("rst_refill", {31'b0, refill}, 32'd0);
    chk("rst_read_l2", {31'b0, rl2}, 32'd0);
    chk("rst_way", {30'b0, way}, 32'd0);
    chk("rst_tag_l2", {11'b0, tag_l2}, 32'd0);
    chk("rst_index_l2", {27'b0, index_l2}, 32'd0);
    chk("rst_hit_cnt", {16'b0, hit_cnt}, 32'd0);
    chk("rst_miss_cnt", {16'b0, miss_cnt}, 32'd0);

    // Cold miss, L2 data 3 cycles late; {0x000123,01} = 0x48D -> tag 0x24, index 0x0D
    fetch(24'h000123, 2'd1, 3, 1'b0);
    chk("cold_miss_pulses", d_miss, 32'd1);
    chk("cold_read_l2_cycles", d_rl2, 32'd4);
    chk("cold_refill_cycles", d_refill, 32'd1);
    chk("cold_refill_way", {30'b0, m_refill_way}, 32'd0);
    chk("cold_hit_pulses", d_hit, 32'd1);
    chk("cold_stall_cycles", d_stall, 32'd7);
    chk("cold_tag_l2", {11'b0, m_l2_tag}, 32'h24);
    chk("cold_index_l2", {27'b0, m_l2_idx}, 32'h0D);
    @(negedge clk);
    chk("cold_hit_cnt", {16'b0, hit_cnt}, 32'd1);
    chk("cold_miss_cnt", {16'b0, miss_cnt}, 32'd1);

    // Re-fetch: pure hit
    fetch(24'h000123, 2'd1, 0, 1'b0);
    chk("rehit_stall_cycles", d_stall, 32'd1);
    chk("rehit_hit_pulses", d_hit, 32'd1);
    chk("rehit_way", {30'b0, m_hit_way}, 32'd0);
    chk("rehit_read_l2", d_rl2, 32'd0);
    chk("rehit_miss", d_miss, 32'd0);
    @(negedge clk);
    chk("rehit_hit_cnt", {16'b0, hit_cnt}, 32'd2);

    // 4-way instance, set 2
    sel = 1'b1;
    @(negedge clk);
    chk("w4_rst_hit_cnt", {16'b0, hit_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      fetch(tl[i], 2'd2, 0, 1'b0);
      chk("w4_fill_way", {30'b0, m_refill_way}, i);
      chk("w4_fill_miss", d_miss, 32'd1);
    end
    fetch(tl[0], 2'd2, 0, 1'b0);
    chk("w4_hitA_hit", d_hit, 32'd1);
    chk("w4_hitA_miss", d_miss, 32'd0);
    chk("w4_hitA_way", {30'b0, m_hit_way}, 32'd0);
    // PLRU after A,B,C,D,A: root->right, right node->left => way 2
    fetch(tl[4], 2'd2, 0, 1'b0);
    chk("w4_E_miss", d_miss, 32'd1);
    chk("w4_E_victim", {30'b0, m_refill_way}, 32'd2);
    chk("w4_valid_full", {28'b0, u_dut4.valid_q[2]}, 32'hF);

    // Flush alone
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("w4_flush_valid", {28'b0, u_dut4.valid_q[2]}, 32'h0);
    chk("w4_flush_no_stall", {31'b0, stall}, 32'd0);
    fetch(tl[0], 2'd2, 0, 1'b0);
    chk("w4_postflush_miss", d_miss, 32'd1);
    chk("w4_postflush_way", {30'b0, m_refill_way}, 32'd0);
    chk("w4_postflush_hit", d_hit, 32'd1);
    @(negedge clk);
    chk("w4_hit_cnt_7", {16'b0, hit_cnt}, 32'd7);
    chk("w4_miss_cnt_6", {16'b0, miss_cnt}, 32'd6);

    // Flush and read together on a cached line
    fetch(tl[0], 2'd2, 0, 1'b1);
    chk("w4_flushread_miss", d_miss, 32'd1);
    chk("w4_flushread_refill", d_refill, 32'd1);
    chk("w4_flushread_hit", d_hit, 32'd1);
    @(negedge clk);
    chk("w4_hit_cnt_8", {16'b0, hit_cnt}, 32'd8);
    chk("w4_miss_cnt_7", {16'b0, miss_cnt}, 32'd7);

    // Back to the 2-way instance: saturation of a 4-bit counter
    sel = 1'b0;
    for (int i = 0; i < 20; i++) fetch(24'h000123, 2'd1, 0, 1'b0);
    chk("sat_last_hit", d_hit, 32'd1);
    @(negedge clk);
    chk("sat_hit_cnt", {16'b0, hit_cnt}, 32'd15);

    // Clear coinciding with a hit pulse
    fetch(24'h000123, 2'd1, 0, 1'b0);
    chk("clr_hit_pulse", {31'b0, hit}, 32'd1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_hit_cnt", {16'b0, hit_cnt}, 32'd0);
    chk("clr_miss_cnt", {16'b0, miss_cnt}, 32'd0);

    // Reset in the middle of ALLOCATE
    @(negedge clk);
    tag = 24'h000456; idx = 2'd1; read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    @(negedge clk);
    chk("abort_in_allocate", {31'b0, rl2}, 32'd1);
    chk("abort_victim_way", {30'b0, way}, 32'd1);
    nrst2 = 1'b0;
    #1;
    chk("abort_stall", {31'b0, stall}, 32'd0);
    chk("abort_read_l2", {31'b0, rl2}, 32'd0);
    chk("abort_miss", {31'b0, miss}, 32'd0);
    chk("abort_way", {30'b0, way}, 32'd0);
    @(negedge clk);
    nrst2 = 1'b1;
    fetch(24'h000456, 2'd1, 0, 1'b0);
    chk("abort_refetch_miss", d_miss, 32'd1);
    chk("abort_refetch_way", {30'b0, m_refill_way}, 32'd0);
    chk("abort_refetch_hit", d_hit, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
